// File: rtl/fabric_config_loader.sv
// Serializes host config words LSB-first into the fabric shift chain, returns tail bits as readback words,
// then strobes set; 1 bit/cycle with >=1 idle cycle per word, host stalled via in_ready, readback has no backpressure.
module fabric_config_loader #(
  parameter int WORD_W     = 32,
  parameter int CHAIN_LEN  = 1024,
  parameter int SET_CYCLES = 2,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              cfg_shift_out,
  output logic              cfg_set_out,
  output logic              cfg_cen,
  input  logic              cfg_shift_return,
  output logic              busy,
  output logic              done
);

  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SW = $clog2(SET_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WAIT_WORD, SHIFT, SET, DONE} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] rb;
  logic [IW-1:0]     idx;
  logic [CNT_W-1:0]  total;
  logic [SW-1:0]     set_cnt;
  logic              rb_vld_q;
  logic              chain_full;
  logic              last_bit;

  // chain_full marks the final chain bit, which may end a partial word early
  assign chain_full = (total == CNT_W'(CHAIN_LEN - 1));
  assign last_bit   = (idx == IW'(WORD_W - 1)) || chain_full;
  assign rb_data    = rb;
  assign rb_valid   = rb_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    cfg_cen       = 1'b0;
    cfg_shift_out = 1'b0;
    cfg_set_out   = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WAIT_WORD;
      end
      WAIT_WORD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        cfg_cen       = 1'b1;
        cfg_shift_out = shreg[0];
        if (last_bit) state_nxt = chain_full ? SET : WAIT_WORD;
      end
      SET: begin
        cfg_cen     = 1'b1;
        cfg_set_out = 1'b1;
        if (set_cnt == SW'(SET_CYCLES - 1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      rb       <= '0;
      idx      <= '0;
      total    <= '0;
      set_cnt  <= '0;
      rb_vld_q <= 1'b0;
    end else begin
      rb_vld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            total <= '0;
            rb    <= '0;
          end
        end
        WAIT_WORD: begin
          // rb is cleared per word so unused upper bits of a partial word read 0
          if (in_valid) begin
            shreg <= in_data;
            idx   <= '0;
            rb    <= '0;
          end
        end
        SHIFT: begin
          shreg   <= shreg >> 1;
          rb[idx] <= cfg_shift_return;
          idx     <= idx + IW'(1);
          if (total != CNT_W'(CHAIN_LEN)) total <= total + CNT_W'(1);
          if (last_bit) begin
            rb_vld_q <= 1'b1;
            set_cnt  <= '0;
          end
        end
        SET: set_cnt <= set_cnt + SW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Loads a 20-bit chain of 8-bit words through fabric_config_loader against a behavioural tile chain model.
module tb_fabric_config_loader;

  localparam int WW = 8;
  localparam int CL = 20;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic          cfg_shift_out;
  logic          cfg_set_out;
  logic          cfg_cen;
  logic          cfg_shift_return;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fabric_config_loader #(
    .WORD_W(WW), .CHAIN_LEN(CL), .SET_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rb_data(rb_data), .rb_valid(rb_valid),
    .cfg_shift_out(cfg_shift_out), .cfg_set_out(cfg_set_out), .cfg_cen(cfg_cen),
    .cfg_shift_return(cfg_shift_return), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_shift = 0, n_set = 0, n_done = 0, n_acc = 0;

  logic [CL-1:0] chain = 20'h51234;
  logic [CL-1:0] committed = '0;
  bit            exp_bits[$];
  logic [WW-1:0] exp_rb[$];

  assign cfg_shift_return = chain[0];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Tile chain: shifts toward the tail when enabled, commits on set.
  always @(posedge clk) begin
    if (rst && cfg_cen) begin
      if (cfg_set_out) committed <= chain;
      else             chain <= {cfg_shift_out, chain[CL-1:1]};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (cfg_cen && !cfg_set_out) begin
        n_shift <= n_shift + 1;
        chk("shift_q_nonempty", 32'(exp_bits.size() != 0), 1);
        if (exp_bits.size() != 0) chk("shift_bit", 32'(cfg_shift_out), 32'(exp_bits.pop_front()));
      end
      if (cfg_set_out) begin
        n_set <= n_set + 1;
        chk("set_cen", 32'(cfg_cen), 1);
        chk("set_shift_out", 32'(cfg_shift_out), 0);
      end
      if (rb_valid) begin
        chk("rb_q_nonempty", 32'(exp_rb.size() != 0), 1);
        if (exp_rb.size() != 0) chk("rb_word", 32'(rb_data), 32'(exp_rb.pop_front()));
      end
      if (done) n_done <= n_done + 1;
      if (in_valid && in_ready) n_acc <= n_acc + 1;
    end
  end

  task automatic expect_load(input logic [WW-1:0] w0, w1, w2, output logic [CL-1:0] ec);
    logic [CL-1:0] snap;
    snap = chain;
    for (int i = 0; i < 8; i++) exp_bits.push_back(w0[i]);
    for (int i = 0; i < 8; i++) exp_bits.push_back(w1[i]);
    for (int i = 0; i < 4; i++) exp_bits.push_back(w2[i]);
    exp_rb.push_back(snap[7:0]);
    exp_rb.push_back(snap[15:8]);
    exp_rb.push_back({4'b0, snap[19:16]});
    ec = {w2[3:0], w1, w0};
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    chk("ready_seen", 32'(in_ready), 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load(input logic [WW-1:0] w0, w1, w2, input int gap, input bit poke);
    logic [CL-1:0] ec, snap;
    logic [WW-1:0] w[3];
    int b_shift, b_set, b_done, b_acc;
    w[0] = w0; w[1] = w1; w[2] = w2;
    b_shift = n_shift; b_set = n_set; b_done = n_done; b_acc = n_acc;
    expect_load(w0, w1, w2, ec);
    in_data = w0; in_valid = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      in_data = w[k]; in_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      if (poke && k == 0) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      if (gap > 0 && k < 2) begin
        in_valid = 1'b0;
        wait_ready();
        snap = chain;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_ready", 32'(in_ready), 1);
          chk("gap_cen", 32'(cfg_cen), 0);
          chk("gap_chain_hold", 32'(chain), 32'(snap));
        end
      end
    end
    in_data = 8'hEE; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("done_seen", 32'(done), 1);
    if (poke) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stay_idle", 32'(busy), 0);
    in_valid = 1'b0;
    chk("shift_cycles", 32'(n_shift - b_shift), CL);
    chk("set_cycles", 32'(n_set - b_set), SC);
    chk("done_pulses", 32'(n_done - b_done), 1);
    chk("words_taken", 32'(n_acc - b_acc), 3);
    chk("committed", 32'(committed), 32'(ec));
    chk("bits_left", 32'(exp_bits.size()), 0);
    chk("rb_left", 32'(exp_rb.size()), 0);
  endtask

  initial begin
    logic [CL-1:0] ec, prev;
    int b_shift, b_set;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_cen", 32'(cfg_cen), 0);
    chk("rst_set", 32'(cfg_set_out), 0);
    chk("rst_rb", 32'({rb_valid, rb_data}), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b1;

    load(8'hA5, 8'h3C, 8'hF6, 0, 1'b0);
    load(8'hFF, 8'h00, 8'hFF, 5, 1'b1);
    load(8'hFF, 8'hFF, 8'hFF, 0, 1'b0);
    load(8'h12, 8'h34, 8'h05, 0, 1'b0);
    load(8'h12, 8'h34, 8'h05, 5, 1'b0);

    // Reset during the second word: no commit, then a clean reload
    expect_load(8'h5A, 8'hC3, 8'h0F, ec);
    prev = committed; b_shift = n_shift; b_set = n_set;
    in_data = 8'h5A; in_valid = 1'b1;
    pulse_start();
    wait_ready();
    @(posedge clk); #1 in_data = 8'hC3;
    for (int i = 0; i < 100 && (n_shift - b_shift) < 9; i++) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_shifts", 32'(n_shift - b_shift), 9);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cen", 32'({cfg_cen, cfg_set_out, cfg_shift_out}), 0);
    chk("mid_rst_rb", 32'({rb_valid, rb_data}), 0);
    exp_bits.delete(); exp_rb.delete();
    in_valid = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("mid_rst_no_set", 32'(n_set - b_set), 0);
    chk("mid_rst_commit_kept", 32'(committed), 32'(prev));
    load(8'h5A, 8'hC3, 8'h0F, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
